// File: rtl/uart_rx_bit_sampler_if.sv
// Signal bundle between the serial line / bit sampler and its SIPO consumer.
// The slave side is the sampler itself: it receives rx_in and drives the
// per-bit strobe and the frame status pulses.
interface uart_rx_bit_sampler_if;
  logic rx_in;       // asynchronous serial line, idle high
  logic sipo_data;   // last sampled data bit, held between strobes
  logic sipo_shift;  // one-cycle strobe per data bit
  logic sipo_valid;  // one-cycle pulse: clean frame received
  logic perror;      // one-cycle pulse: parity mismatch
  logic ferror;      // one-cycle pulse: stop bit sampled low
  logic busy;        // receiver is not idle

  // Line driver / consumer side.
  modport master (
    output rx_in,
    input  sipo_data,
    input  sipo_shift,
    input  sipo_valid,
    input  perror,
    input  ferror,
    input  busy
  );

  // Bit sampler side.
  modport slave (
    input  rx_in,
    output sipo_data,
    output sipo_shift,
    output sipo_valid,
    output perror,
    output ferror,
    output busy
  );
endinterface

// File: rtl/uart_rx_bit_sampler.sv
// UART receive front-end: synchronizes and oversamples the serial line,
// finds start bits, strobes each mid-bit data sample out to a SIPO register
// and reports frame status (clean / parity error / framing error).
module uart_rx_bit_sampler #(
  parameter int BAUD_DIV   = 326,  // clk cycles per oversample tick
  parameter int OVERSAMPLE = 16,   // ticks per bit period, even, >= 4
  parameter int DATA_BITS  = 8,    // data bits per frame, LSB first
  parameter int PARITY_EN  = 1,    // 1: a parity bit follows the data
  parameter int PARITY_ODD = 0     // 0: even parity, 1: odd parity
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_rx_bit_sampler_if.slave rx_if
);

  localparam int DIV_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BAUD_DIV - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              PAR_EN_B  = (PARITY_EN != 0);
  localparam logic              PAR_ODD_B = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Synchronizer
  logic rx_meta_reg;
  logic rx_s_reg;

  // FSM and datapath registers
  state_t            state_reg,      state_next;
  logic [DIV_W-1:0]  div_cnt_reg,    div_cnt_next;
  logic [TICK_W-1:0] tick_cnt_reg,   tick_cnt_next;
  logic [BIT_W-1:0]  bit_cnt_reg,    bit_cnt_next;
  logic              parity_acc_reg, parity_acc_next;
  logic              mismatch_reg,   mismatch_next;

  // Registered outputs
  logic sipo_data_reg,  sipo_data_next;
  logic sipo_shift_reg, sipo_shift_next;
  logic sipo_valid_reg, sipo_valid_next;
  logic perror_reg,     perror_next;
  logic ferror_reg,     ferror_next;

  // Tick and sample-point qualifiers
  logic tick;
  logic half_sample;
  logic full_sample;

  assign tick        = (div_cnt_reg == DIV_LAST);
  assign half_sample = tick && (tick_cnt_reg == HALF_LAST);
  assign full_sample = tick && (tick_cnt_reg == FULL_LAST);

  // Two-flop synchronizer; resets to the idle (high) line level so that a
  // reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx_if.rx_in;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      div_cnt_reg    <= '0;
      tick_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      parity_acc_reg <= 1'b0;
      mismatch_reg   <= 1'b0;
      sipo_data_reg  <= 1'b0;
      sipo_shift_reg <= 1'b0;
      sipo_valid_reg <= 1'b0;
      perror_reg     <= 1'b0;
      ferror_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_cnt_reg    <= div_cnt_next;
      tick_cnt_reg   <= tick_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      parity_acc_reg <= parity_acc_next;
      mismatch_reg   <= mismatch_next;
      sipo_data_reg  <= sipo_data_next;
      sipo_shift_reg <= sipo_shift_next;
      sipo_valid_reg <= sipo_valid_next;
      perror_reg     <= perror_next;
      ferror_reg     <= ferror_next;
    end
  end

  // Next-state, counter and output-pulse logic.
  always_comb begin
    state_next      = state_reg;
    div_cnt_next    = tick ? '0 : div_cnt_reg + 1'b1;
    tick_cnt_next   = tick ? tick_cnt_reg + 1'b1 : tick_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    parity_acc_next = parity_acc_reg;
    mismatch_next   = mismatch_reg;
    sipo_data_next  = sipo_data_reg;
    sipo_shift_next = 1'b0;
    sipo_valid_next = 1'b0;
    perror_next     = 1'b0;
    ferror_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Falling edge: realign the tick grid to the start edge so every
        // later sample lands at a fixed offset into its bit.
        if (!rx_s_reg) begin
          state_next      = ST_START;
          div_cnt_next    = '0;
          tick_cnt_next   = '0;
          bit_cnt_next    = '0;
          parity_acc_next = 1'b0;
          mismatch_next   = 1'b0;
        end
      end

      ST_START: begin
        // Mid-start check rejects short glitches on the line.
        if (half_sample) begin
          tick_cnt_next = '0;
          state_next    = rx_s_reg ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (full_sample) begin
          tick_cnt_next   = '0;
          sipo_data_next  = rx_s_reg;
          sipo_shift_next = 1'b1;
          parity_acc_next = parity_acc_reg ^ rx_s_reg;
          bit_cnt_next    = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = PAR_EN_B ? ST_PARITY : ST_STOP;
          end
        end
      end

      ST_PARITY: begin
        if (full_sample) begin
          tick_cnt_next = '0;
          mismatch_next = parity_acc_reg ^ rx_s_reg ^ PAR_ODD_B;
          state_next    = ST_STOP;
        end
      end

      ST_STOP: begin
        // Stop is judged at mid-bit so the receiver is back in IDLE half a
        // bit early and can catch a start bit that follows immediately.
        if (full_sample) begin
          tick_cnt_next = '0;
          if (rx_s_reg) begin
            sipo_valid_next = !mismatch_reg;
            perror_next     = mismatch_reg;
            state_next      = ST_IDLE;
          end else begin
            ferror_next = 1'b1;
            state_next  = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        // A line held low after a framing error must go high before a new
        // start bit is accepted.
        if (rx_s_reg) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rx_if.sipo_data  = sipo_data_reg;
  assign rx_if.sipo_shift = sipo_shift_reg;
  assign rx_if.sipo_valid = sipo_valid_reg;
  assign rx_if.perror     = perror_reg;
  assign rx_if.ferror     = ferror_reg;
  assign rx_if.busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Scoreboard bench for uart_rx_bit_sampler: each frame sent pushes the
// expected strobes and status pulse (with expected spacing) into a queue; a
// monitor pops and compares whenever the receiver produces an output event.
module tb_uart_rx_bit_sampler;

  localparam int BAUD_DIV   = 2;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int T          = BAUD_DIV * OVERSAMPLE;

  localparam int K_SHIFT = 0;
  localparam int K_VALID = 1;
  localparam int K_PERR  = 2;
  localparam int K_FERR  = 3;

  typedef struct {
    int         kind;
    logic       data_bit;
    logic [7:0] byte_val;
    int         gap;       // expected clk since previous event, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];

  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  int     checks = 0;
  int     fails  = 0;
  longint cycle  = 0;

  // Chaining info used to predict the spacing from one frame's status pulse
  // to the next frame's first strobe (2T plus the extra line time between).
  bit chain_ok  = 1'b0;
  int chain_gap = 0;

  uart_rx_bit_sampler_if bus ();

  uart_rx_bit_sampler #(
    .BAUD_DIV  (BAUD_DIV),
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS (DATA_BITS),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx_if(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  // Monitor: one check per output event, plus a sipo_data hold check.
  logic [7:0] win        = 8'h00;
  logic       prev_data  = 1'b0;
  logic       prev_reset = 1'b1;
  longint     last_ev    = 0;

  always @(negedge clk) begin
    int   n;
    int   kind;
    exp_t e;
    n = int'(bus.sipo_shift) + int'(bus.sipo_valid) + int'(bus.perror) + int'(bus.ferror);
    if (!reset && !prev_reset) begin
      checks++;
      if (!bus.sipo_shift && bus.sipo_data !== prev_data) begin
        fails++;
        $display("FAIL data_hold: got %b required %b at cycle %0d", bus.sipo_data, prev_data, cycle);
      end
    end
    if (n > 0) begin
      checks++;
      if (n > 1) begin
        fails++;
        $display("FAIL exclusive: got %0d simultaneous events required 1 at cycle %0d", n, cycle);
      end else begin
        kind = bus.sipo_shift ? K_SHIFT : bus.sipo_valid ? K_VALID : bus.perror ? K_PERR : K_FERR;
        if (bus.sipo_shift) win = {bus.sipo_data, win[7:1]};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got kind %0d required none at cycle %0d", kind, cycle);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != kind) begin
            fails++;
            $display("FAIL event_kind: got %0d required %0d at cycle %0d", kind, e.kind, cycle);
          end else if (kind == K_SHIFT && bus.sipo_data !== e.data_bit) begin
            fails++;
            $display("FAIL shift_bit: got %b required %b at cycle %0d", bus.sipo_data, e.data_bit, cycle);
          end else if (kind == K_VALID && win !== e.byte_val) begin
            fails++;
            $display("FAIL sipo_byte: got %h required %h at cycle %0d", win, e.byte_val, cycle);
          end else if (e.gap != 0 && (cycle - last_ev) != longint'(e.gap)) begin
            fails++;
            $display("FAIL event_gap: got %0d required %0d at cycle %0d", cycle - last_ev, e.gap, cycle);
          end
        end
      end
      last_ev = cycle;
    end
    prev_data  = bus.sipo_data;
    prev_reset = reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(int n);
    repeat (n) tick();
  endtask

  task automatic chk(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic drive_bit(logic b);
    bus.rx_in = b;
    wait_cycles(T);
  endtask

  task automatic push_shift(logic b, int gap);
    exp_t e;
    e.kind = K_SHIFT; e.data_bit = b; e.byte_val = 8'h00; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Send one frame and predict its events from the frame contents alone.
  task automatic send_frame(logic [7:0] d, logic pbit, logic stop, int low_extra, int idle_after);
    exp_t e;
    logic mismatch;
    $display("frame data=%h parity=%b stop=%b low_extra=%0d idle=%0d", d, pbit, stop, low_extra, idle_after);
    mismatch = (^d) ^ pbit;
    for (int i = 0; i < DATA_BITS; i++) begin
      push_shift(d[i], (i == 0) ? (chain_ok ? 2 * T + chain_gap : 0) : T);
    end
    e.kind     = !stop ? K_FERR : (mismatch ? K_PERR : K_VALID);
    e.data_bit = 1'b0;
    e.byte_val = d;
    e.gap      = 2 * T;
    exp_q.push_back(e);

    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(stop);
    if (!stop) begin
      wait_cycles(low_extra);
      chk("busy_in_break", bus.busy, 1'b1);
    end
    bus.rx_in = 1'b1;
    wait_cycles(idle_after);
    chain_ok  = 1'b1;
    chain_gap = (stop ? 0 : low_extra) + idle_after;
  endtask

  initial begin
    logic [7:0] d;
    logic       pbit;
    logic       stop;
    int         low_extra;
    int         idle_after;

    bus.rx_in = 1'b1;
    reset     = 1'b1;
    wait_cycles(3);
    chk("reset_sipo_data",  bus.sipo_data,  1'b0);
    chk("reset_sipo_shift", bus.sipo_shift, 1'b0);
    chk("reset_sipo_valid", bus.sipo_valid, 1'b0);
    chk("reset_perror",     bus.perror,     1'b0);
    chk("reset_ferror",     bus.ferror,     1'b0);
    chk("reset_busy",       bus.busy,       1'b0);
    reset = 1'b0;
    wait_cycles(10);

    // Clean frame, parity error, framing error with a long break.
    send_frame(8'hA5, 1'b0, 1'b1, 0, 20);
    send_frame(8'h01, 1'b0, 1'b1, 0, 20);
    send_frame(8'h3C, 1'b0, 1'b0, 5 * T, 8);
    chk("busy_after_break", bus.busy, 1'b0);

    // Short glitch: busy briefly, no events.
    $display("glitch low 6 clk");
    bus.rx_in = 1'b0;
    wait_cycles(6);
    bus.rx_in = 1'b1;
    chk("busy_glitch", bus.busy, 1'b1);
    wait_cycles(40);
    chk("busy_glitch_end", bus.busy, 1'b0);
    chain_ok = 1'b0;

    // Back-to-back frames with no idle gap.
    send_frame(8'h55, 1'b0, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0, 20);

    // Reset after the 4th strobe of 0xA5 drops the frame.
    $display("frame data=a5 aborted by reset after 4 strobes");
    d = 8'hA5;
    for (int i = 0; i < 4; i++) push_shift(d[i], (i == 0) ? (2 * T + chain_gap) : T);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    bus.rx_in = d[4];
    wait_cycles(5);
    reset = 1'b1;
    tick();
    chk("abort_sipo_data",  bus.sipo_data,  1'b0);
    chk("abort_sipo_shift", bus.sipo_shift, 1'b0);
    chk("abort_sipo_valid", bus.sipo_valid, 1'b0);
    chk("abort_busy",       bus.busy,       1'b0);
    bus.rx_in = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(20);
    chain_ok = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 0, 20);

    // Randomized frames: occasional parity and stop faults, random gaps.
    for (int k = 0; k < 24; k++) begin
      d          = 8'($urandom);
      pbit       = (^d) ^ ($urandom_range(0, 4) == 0);
      stop       = ($urandom_range(0, 5) != 0);
      low_extra  = stop ? 0 : $urandom_range(0, 2 * T);
      idle_after = stop ? $urandom_range(0, 40) : $urandom_range(4, 40);
      send_frame(d, pbit, stop, low_extra, idle_after);
    end

    wait_cycles(3 * T);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending events required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
